// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO family.
// Depth and count widths are derived from the address width so every user agrees on them.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than an address.
  function automatic int fifo_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered-read output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FWFT   = FIFO_MODE_FWFT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic [ADDR_W:0]   fifo_count,
  input  logic [ADDR_W:0]   af_level,
  input  logic [ADDR_W:0]   ae_level,
  output logic              fifo_overflow,
  output logic              fifo_underflow,
  input  logic              clr_err
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int CNT_W = fifo_cnt_w(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]  wptr;
  logic [CNT_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  // A read on a full FIFO frees a slot in the same edge, so a simultaneous write is still taken.
  assign rd_acc = rd & ~fifo_empty;
  assign wr_acc = wr & (~fifo_full | rd_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + ONE_C;
      end
      if (rd_acc) begin
        rptr <= rptr + ONE_C;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      // A new error event takes priority over a clear arriving in the same cycle.
      if (wr & fifo_full & ~rd_acc) begin
        fifo_overflow <= 1'b1;
      end else if (clr_err) begin
        fifo_overflow <= 1'b0;
      end
      if (rd & fifo_empty) begin
        fifo_underflow <= 1'b1;
      end else if (clr_err) begin
        fifo_underflow <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & rst_n),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Status is decoded only from the registered count, never from wr/rd directly.
  assign fifo_count        = count;
  assign fifo_full         = (count == DEPTH_C);
  assign fifo_empty        = (count == '0);
  assign fifo_almost_full  = (count >= af_level);
  assign fifo_almost_empty = (count <= ae_level);

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_out   = ram_rdata;
    assign data_valid = ~fifo_empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= ram_rdata;
        end
      end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
  end

  // The wrap-bit pointers must always differ by exactly the registered occupancy.
  ptr_count_consistent : assert property (
    @(posedge clk) disable iff (!rst_n) ((wptr - rptr) == count)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: drives an FWFT and a registered-read FIFO with shared stimulus and
// compares both against a queue-based reference model plus a table of explicit expectations.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic       clr_err;
  logic [4:0] af_level;
  logic [4:0] ae_level;

  logic [7:0] fw_data_out, sd_data_out;
  logic       fw_data_valid, sd_data_valid;
  logic       fw_full, sd_full, fw_empty, sd_empty;
  logic       fw_afull, sd_afull, fw_aempty, sd_aempty;
  logic [4:0] fw_count, sd_count;
  logic       fw_ovf, sd_ovf, fw_unf, sd_unf;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] sb_q[$];
  logic       m_ovf, m_unf, m_valid;
  logic [7:0] m_dout;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic       clr;
    logic [4:0] exp_count;
    logic       exp_ovf;
    logic       exp_unf;
    logic       exp_dv;
    logic [7:0] exp_dout;
  } vector_t;

  vector_t vecs[8];

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) dut_fwft (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr                (wr),
    .data_in           (data_in),
    .rd                (rd),
    .data_out          (fw_data_out),
    .data_valid        (fw_data_valid),
    .fifo_full         (fw_full),
    .fifo_empty        (fw_empty),
    .fifo_almost_full  (fw_afull),
    .fifo_almost_empty (fw_aempty),
    .fifo_count        (fw_count),
    .af_level          (af_level),
    .ae_level          (ae_level),
    .fifo_overflow     (fw_ovf),
    .fifo_underflow    (fw_unf),
    .clr_err           (clr_err)
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) dut_std (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr                (wr),
    .data_in           (data_in),
    .rd                (rd),
    .data_out          (sd_data_out),
    .data_valid        (sd_data_valid),
    .fifo_full         (sd_full),
    .fifo_empty        (sd_empty),
    .fifo_almost_full  (sd_afull),
    .fifo_almost_empty (sd_aempty),
    .fifo_count        (sd_count),
    .af_level          (af_level),
    .ae_level          (ae_level),
    .fifo_overflow     (sd_ovf),
    .fifo_underflow    (sd_unf),
    .clr_err           (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the reference model state after an edge.
  task automatic checkOutput(input string tag);
    int         n;
    logic [4:0] mc;
    n  = sb_q.size();
    mc = 5'(n);
    checkVal({tag, ".fw_count"}, 32'(fw_count), 32'(mc));
    checkVal({tag, ".sd_count"}, 32'(sd_count), 32'(mc));
    checkVal({tag, ".full"}, 32'(fw_full), 32'(n == 16));
    checkVal({tag, ".sd_full"}, 32'(sd_full), 32'(n == 16));
    checkVal({tag, ".empty"}, 32'(fw_empty), 32'(n == 0));
    checkVal({tag, ".afull"}, 32'(fw_afull), 32'(mc >= af_level));
    checkVal({tag, ".aempty"}, 32'(fw_aempty), 32'(mc <= ae_level));
    checkVal({tag, ".ovf"}, 32'(fw_ovf), 32'(m_ovf));
    checkVal({tag, ".sd_ovf"}, 32'(sd_ovf), 32'(m_ovf));
    checkVal({tag, ".unf"}, 32'(fw_unf), 32'(m_unf));
    checkVal({tag, ".sd_unf"}, 32'(sd_unf), 32'(m_unf));
    checkVal({tag, ".sd_valid"}, 32'(sd_data_valid), 32'(m_valid));
    checkVal({tag, ".sd_dout"}, 32'(sd_data_out), 32'(m_dout));
    checkVal({tag, ".fw_valid"}, 32'(fw_data_valid), 32'(n != 0));
    if (n != 0) begin
      checkVal({tag, ".fw_dout"}, 32'(fw_data_out), 32'(sb_q[0]));
    end
  endtask

  // Drive one cycle of stimulus and advance the reference model through the same edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d,
                               input logic c, input string tag);
    logic full, empty, racc, wacc;
    wr      = w;
    rd      = r;
    data_in = d;
    clr_err = c;
    full  = (sb_q.size() == 16);
    empty = (sb_q.size() == 0);
    racc  = r && !empty;
    wacc  = w && (!full || racc);
    if (w && full && !racc) m_ovf = 1'b1;
    else if (c)             m_ovf = 1'b0;
    if (r && empty) m_unf = 1'b1;
    else if (c)     m_unf = 1'b0;
    m_valid = racc;
    if (racc) m_dout = sb_q.pop_front();
    if (wacc) sb_q.push_back(d);
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    checkOutput(tag);
  endtask

  task automatic doReset(input logic w, input logic r);
    rst_n   = 1'b0;
    wr      = w;
    rd      = r;
    data_in = 8'hEE;
    sb_q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
    m_dout  = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    checkOutput("reset");
  endtask

  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].clr, $sformatf("row%0d", i));
      checkVal($sformatf("row%0d.count", i), 32'(sd_count), 32'(vecs[i].exp_count));
      checkVal($sformatf("row%0d.ovf", i), 32'(sd_ovf), 32'(vecs[i].exp_ovf));
      checkVal($sformatf("row%0d.unf", i), 32'(fw_unf), 32'(vecs[i].exp_unf));
      checkVal($sformatf("row%0d.dv", i), 32'(sd_data_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) begin
        checkVal($sformatf("row%0d.dout", i), 32'(sd_data_out), 32'(vecs[i].exp_dout));
      end
    end
  endtask

  initial begin
    //            wr    rd    din    clr   cnt     ovf   unf   dv    dout
    vecs[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 8'h20, 1'b0, 5'd16, 1'b0, 1'b0, 1'b1, 8'h30};
    vecs[4] = '{1'b1, 1'b1, 8'hAA, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 8'hAA};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 8'h00};

    rst_n    = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    data_in  = 8'h00;
    clr_err  = 1'b0;
    af_level = 5'd14;
    ae_level = 5'd2;
    doReset(1'b0, 1'b0);
    checkVal("reset.empty", 32'(sd_empty), 32'd1);

    // Fill to full; thresholds are checked against the model at every step.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, $sformatf("fill%0d", i));
      if (i == 13) checkVal("fill13.afull_low", 32'(sd_afull), 32'd0);
      if (i == 14) checkVal("fill14.afull_high", 32'(sd_afull), 32'd1);
      if (i == 3)  checkVal("fill3.aempty_low", 32'(sd_aempty), 32'd0);
    end
    checkVal("fill.full", 32'(sd_full), 32'd1);

    // Overflow on full, then drain shows 0x01..0x10 only.
    runRows(0, 1);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, $sformatf("drain%0d", i));
      checkVal($sformatf("drain%0d.word", i), 32'(sd_data_out), 32'(i));
    end
    runRows(2, 2);

    // Full with simultaneous write and read.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, "refill");
    runRows(3, 3);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "drain2");
    checkVal("drain2.last", 32'(sd_data_out), 32'h20);

    // Empty with simultaneous write and read, then clr_err versus fresh underflow.
    runRows(4, 7);

    // Interleaved pairs push both pointers through several wraps.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, $sformatf("wrap_w%0d", i));
      if (i == 5) checkVal("fwft.show05", 32'(fw_data_out), 32'h05);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, $sformatf("wrap_r%0d", i));
      checkVal($sformatf("wrap_r%0d.word", i), 32'(sd_data_out), 32'(i));
    end

    // Reset mid-stream with sticky flag and pending read data; wr/rd in reset cycle ignored.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "pre_unf");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, "mid");
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "mid_rd");
    doReset(1'b1, 1'b1);
    checkVal("midreset.count", 32'(fw_count), 32'd0);
    checkVal("midreset.empty", 32'(fw_empty), 32'd1);
    checkVal("midreset.unf", 32'(sd_unf), 32'd0);
    checkVal("midreset.dv", 32'(sd_data_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, "post_w");
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "post_r");
    checkVal("post.word", 32'(sd_data_out), 32'h77);

    // Threshold extremes force both almost flags high.
    af_level = 5'd0;
    ae_level = 5'd16;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "thr_empty");
    checkVal("thr.afull0", 32'(fw_afull), 32'd1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, "thr_fill");
    checkVal("thr.aempty16", 32'(fw_aempty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
